// File: rtl/fetch_queue.sv
// Instruction-fetch queue: issues PC fetches, tracks in-flight requests in order,
// and hands PC/instruction pairs to decode. On a redirect it drops wrong-path responses.
module fetch_queue #(
   parameter int DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] current_pc,
   output logic        fetch_stall,
   input  logic        flush,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        id_valid,
   input  logic        id_ready,
   output logic [31:0] id_pc,
   output logic [31:0] id_inst
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [31:0]      pc_mem   [DEPTH];
   logic [31:0]      inst_mem [DEPTH];
   logic [DEPTH-1:0] filled;
   logic [AW-1:0]    alloc_ptr;
   logic [AW-1:0]    fill_ptr;
   logic [AW-1:0]    head_ptr;
   logic [CW-1:0]    count;
   logic [CW-1:0]    drop_cnt;

   logic [CW-1:0]    filled_num;
   logic [CW-1:0]    unfilled;
   logic [CW:0]      occupancy;
   logic [CW-1:0]    flush_drop;
   logic             space;
   logic             req_fire;
   logic             pop;
   logic             drop_en;
   logic             fill_en;

   // Unfilled entries are the ones still owed a response; stale drops share the same budget.
   always_comb begin
      filled_num = '0;
      for (int i = 0; i < DEPTH; i++) begin
         filled_num = filled_num + CW'(filled[i]);
      end
      unfilled       = count - filled_num;
      occupancy      = {1'b0, count} + {1'b0, drop_cnt};
      space          = occupancy < (CW+1)'(DEPTH);
      imem_req_valid = !rst && !flush && space;
      req_fire       = imem_req_valid && imem_req_ready;
      fetch_stall    = !req_fire && !flush;
      id_valid       = !rst && !flush && filled[head_ptr] && (count != '0);
      pop            = id_valid && id_ready;
      drop_en        = imem_rsp_valid && (drop_cnt != '0);
      fill_en        = imem_rsp_valid && (drop_cnt == '0) && (unfilled != '0);
      flush_drop     = drop_cnt + unfilled
                       - CW'(imem_rsp_valid && ((drop_cnt != '0) || (unfilled != '0)));
   end

   assign imem_req_addr = current_pc;
   assign id_pc         = pc_mem[head_ptr];
   assign id_inst       = inst_mem[head_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         alloc_ptr <= '0;
         fill_ptr  <= '0;
         head_ptr  <= '0;
         count     <= '0;
         drop_cnt  <= '0;
         filled    <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            pc_mem[i]   <= '0;
            inst_mem[i] <= '0;
         end
      end else if (flush) begin
         alloc_ptr <= '0;
         fill_ptr  <= '0;
         head_ptr  <= '0;
         count     <= '0;
         filled    <= '0;
         drop_cnt  <= flush_drop;
      end else begin
         if (req_fire) begin
            pc_mem[alloc_ptr] <= current_pc;
            filled[alloc_ptr] <= 1'b0;
            alloc_ptr         <= alloc_ptr + AW'(1);
         end
         if (drop_en) begin
            drop_cnt <= drop_cnt - CW'(1);
         end
         if (fill_en) begin
            inst_mem[fill_ptr] <= imem_rsp_data;
            filled[fill_ptr]   <= 1'b1;
            fill_ptr           <= fill_ptr + AW'(1);
         end
         if (pop) begin
            filled[head_ptr] <= 1'b0;
            head_ptr         <= head_ptr + AW'(1);
         end
         count <= count + CW'(req_fire) - CW'(pop);
      end
   end

endmodule
